// File: rtl/arty_gpio_bridge_if.sv
// GPIO bus between the pulpino GPIO block and the Arty board-I/O bridge.
// Only the low 32 bits of each vector are used, matching the pulpino GPIO port.
interface arty_gpio_bridge_if;
    logic [31:0] gpio_out_i;
    logic [31:0] gpio_dir_i;
    logic [31:0] gpio_in_o;

    modport master (output gpio_out_i, output gpio_dir_i, input gpio_in_o);
    modport slave  (input gpio_out_i, input gpio_dir_i, output gpio_in_o);
endinterface

// File: rtl/arty_gpio_bridge.sv
// Arty board-I/O bridge: SoC reset sequencing from MMCM lock, debounced pad
// inputs onto gpio_in, and per-channel direct/invert/blink/PWM pad outputs.
module arty_gpio_bridge #(
    parameter int N_IN         = 4,
    parameter int N_OUT        = 4,
    parameter int IN_BASE      = 0,
    parameter int OUT_BASE     = 8,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int RST_HOLD     = 16,
    parameter int BLINK_SHIFT  = 24,
    parameter int PWM_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    output logic                 soc_rst_no,
    arty_gpio_bridge_if.slave    gpio,
    input  logic [2*N_OUT-1:0]   mode_i,
    input  logic [PWM_W-1:0]     pwm_duty_i,
    input  logic [N_IN-1:0]      pad_in_i,
    output logic [N_OUT-1:0]     pad_out_o
);

    typedef enum logic [0:0] {HOLD = 1'b0, RUN = 1'b1} state_t;

    localparam int LOCK_W = $clog2(RST_HOLD + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [LOCK_W-1:0]      LOCK_MAX  = LOCK_W'(RST_HOLD - 1);
    localparam logic [LOCK_W-1:0]      LOCK_ONE  = LOCK_W'(1);
    localparam logic [DB_W-1:0]        DB_MAX    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]        DB_ONE    = DB_W'(1);
    localparam logic [BLINK_SHIFT:0]   BLINK_ONE = (BLINK_SHIFT+1)'(1);
    localparam logic [PWM_W-1:0]       PWM_ONE   = PWM_W'(1);

    logic                  lock_meta_r;
    logic                  lock_s_r;
    state_t                state_r;
    state_t                state_next_s;
    logic [LOCK_W-1:0]     lock_cnt_r;
    logic [LOCK_W-1:0]     lock_cnt_next_s;
    logic                  soc_rst_r;

    logic [N_IN-1:0]       pad_meta_r;
    logic [N_IN-1:0]       pad_sync_r;
    logic [N_IN-1:0]       stable_r;
    logic [DB_W-1:0]       db_cnt_r [N_IN];
    logic [31:0]           gpio_in_s;

    logic [BLINK_SHIFT:0]  blink_cnt_r;
    logic [PWM_W-1:0]      pwm_cnt_r;
    logic [N_OUT-1:0]      b_s;
    logic [N_OUT-1:0]      pad_run_s;
    logic [N_OUT-1:0]      pad_next_s;
    logic [N_OUT-1:0]      pad_out_r;

    // Double-synchronise the MMCM lock, which is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_s_r    <= lock_s_r ^ (lock_s_r ^ lock_meta_r);
        end
    end

    // Reset sequencer state, lock counter and registered SoC reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HOLD;
            lock_cnt_r <= '0;
            soc_rst_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lock_cnt_r <= lock_cnt_next_s;
            soc_rst_r  <= (state_next_s == RUN);
        end
    end

    // Lock must be seen for RST_HOLD consecutive cycles; any drop restarts the count.
    always_comb begin
        state_next_s    = state_r;
        lock_cnt_next_s = lock_cnt_r;
        case (state_r)
            HOLD: begin
                if (lock_s_r) begin
                    if (lock_cnt_r == LOCK_MAX) begin
                        state_next_s    = RUN;
                        lock_cnt_next_s = '0;
                    end else begin
                        lock_cnt_next_s = lock_cnt_r + LOCK_ONE;
                    end
                end else begin
                    lock_cnt_next_s = '0;
                end
            end
            RUN: begin
                lock_cnt_next_s = '0;
                if (!lock_s_r) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s    = HOLD;
                lock_cnt_next_s = '0;
            end
        endcase
    end

    // Per-pad synchroniser and debouncer; a change is accepted only after DEBOUNCE_CYC differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_meta_r <= '0;
            pad_sync_r <= '0;
            stable_r   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            pad_meta_r <= pad_in_i;
            pad_sync_r <= pad_meta_r;
            for (int i = 0; i < N_IN; i++) begin
                if (pad_sync_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_MAX) begin
                    stable_r[i] <= pad_sync_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // Place the debounced pads at IN_BASE; all other gpio_in bits read 0.
    always_comb begin
        gpio_in_s = '0;
        gpio_in_s[IN_BASE +: N_IN] = stable_r;
    end

    assign gpio.gpio_in_o = gpio_in_s;

    // Free-running blink and PWM timebases, shared by all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            pwm_cnt_r   <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
        end
    end

    // Per-channel mode mux; pads are held low while the SoC is in reset.
    always_comb begin
        b_s       = '0;
        pad_run_s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            b_s[i] = gpio.gpio_out_i[OUT_BASE + i] & gpio.gpio_dir_i[OUT_BASE + i];
            case (mode_i[2*i +: 2])
                2'b00:   pad_run_s[i] = b_s[i];
                2'b01:   pad_run_s[i] = ~b_s[i];
                2'b10:   pad_run_s[i] = b_s[i] & blink_cnt_r[BLINK_SHIFT];
                2'b11:   pad_run_s[i] = b_s[i] & (pwm_cnt_r < pwm_duty_i);
                default: pad_run_s[i] = 1'b0;
            endcase
        end
        if (state_r == RUN) begin
            pad_next_s = pad_run_s;
        end else begin
            pad_next_s = '0;
        end
    end

    // Registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out_r <= '0;
        end else begin
            pad_out_r <= pad_next_s;
        end
    end

    assign pad_out_o  = pad_out_r;
    assign soc_rst_no = soc_rst_r;

endmodule

// File: tb/tb_arty_gpio_bridge.sv
// Scoreboard bench for arty_gpio_bridge: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_arty_gpio_bridge;

    localparam int N_IN = 4, N_OUT = 4, IN_BASE = 0, OUT_BASE = 8;
    localparam int DEBOUNCE_CYC = 4, RST_HOLD = 8, BLINK_SHIFT = 3, PWM_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pll_locked;
    logic                soc_rst_no;
    logic [2*N_OUT-1:0]  mode;
    logic [PWM_W-1:0]    duty;
    logic [N_IN-1:0]     pad_in;
    logic [N_OUT-1:0]    pad_out;

    arty_gpio_bridge_if bus ();

    arty_gpio_bridge #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE),
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_HOLD(RST_HOLD),
        .BLINK_SHIFT(BLINK_SHIFT), .PWM_W(PWM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soc_rst_no(soc_rst_no),
        .gpio(bus.slave), .mode_i(mode), .pwm_duty_i(duty),
        .pad_in_i(pad_in), .pad_out_o(pad_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] tag;
        logic [1:0]  sel;   // 0 soc_rst_no, 1 gpio_in_o, 2 pad_out_o
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference cycle count since reset release; the spec's free-running counters follow it.
    logic [31:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 32'd0;
        else        mcnt <= mcnt + 32'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input logic [95:0] tag, input logic [1:0] sel, input logic [31:0] e);
        chk_t c;
        c.tag = tag;
        c.sel = sel;
        c.exp = e;
        sb.push_back(c);
    endtask

    // Expected pad pattern in RUN; cb is the counter value before the edge.
    function automatic logic [3:0] pad_model(input logic [7:0] md, input logic [31:0] dir,
                                             input logic [31:0] outv, input logic [7:0] dty,
                                             input logic [31:0] cb);
        logic [3:0] r;
        logic       b;
        r = 4'd0;
        for (int i = 0; i < 4; i++) begin
            b = outv[8+i] & dir[8+i];
            case (md[2*i +: 2])
                2'b00:   r[i] = b;
                2'b01:   r[i] = ~b;
                2'b10:   r[i] = b & cb[3];
                default: r[i] = b & (cb[7:0] < dty);
            endcase
        end
        return r;
    endfunction

    task automatic expect_pad_model(input logic [95:0] tag);
        expect_v(tag, 2'd2, {28'd0, pad_model(mode, bus.gpio_dir_i, bus.gpio_out_i, duty, mcnt - 32'd1)});
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.sel)
                2'd0:    act = {31'd0, soc_rst_no};
                2'd1:    act = bus.gpio_in_o;
                default: act = {28'd0, pad_out};
            endcase
            n_checks = n_checks + 1;
            if (act !== c.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %h expected %h at %0t", c.tag, act, c.exp, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] dirv [4];
    logic [1:0] outv [4];
    logic [3:0] expv [4];
    logic [3:0] prev;
    logic [7:0] duties [3];

    initial begin
        dirv   = '{2'b11, 2'b11, 2'b11, 2'b00};
        outv   = '{2'b01, 2'b10, 2'b11, 2'b11};
        expv   = '{4'b0011, 4'b0000, 4'b0001, 4'b0010};
        duties = '{8'd64, 8'd0, 8'd255};

        rst_n = 1'b0; pll_locked = 1'b0; mode = 8'd0; duty = 8'd0; pad_in = 4'd0;
        bus.gpio_out_i = 32'd0; bus.gpio_dir_i = 32'd0;
        repeat (3) step();
        expect_v("rst_soc", 2'd0, 32'd0);
        expect_v("rst_gpio_in", 2'd1, 32'd0);
        expect_v("rst_pad", 2'd2, 32'd0);
        step();
        rst_n = 1'b1;
        mode  = 8'b0000_0001;                 // ch0 invert: must still read 0 in HOLD

        // Lock sequencing
        repeat (10) begin
            step();
            expect_v("hold_soc", 2'd0, 32'd0);
            expect_v("hold_pad", 2'd2, 32'd0);
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_v("lock_soc", 2'd0, (k >= 10) ? 32'd1 : 32'd0);
            expect_v("lock_pad", 2'd2, 32'd0);
        end
        step();
        expect_v("run_invert", 2'd2, 32'h1);

        // Direct/invert with one-cycle output latency
        prev = 4'b0001;
        mode = 8'b0000_0100;
        for (int v = 0; v < 4; v++) begin
            bus.gpio_dir_i[9:8] = dirv[v];
            bus.gpio_out_i[9:8] = outv[v];
            expect_v("dir_latency", 2'd2, {28'd0, prev});
            step();
            expect_v("dir_inv", 2'd2, {28'd0, expv[v]});
            prev = expv[v];
        end

        // Debounce: short glitch rejected, steady level accepted after 2+DEBOUNCE_CYC
        pad_in = 4'b0001;
        repeat (3) step();
        pad_in = 4'b0000;
        repeat (8) begin
            step();
            expect_v("glitch", 2'd1, 32'd0);
        end
        pad_in = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            expect_v("db_rise", 2'd1, (k >= 6) ? 32'h1 : 32'h0);
        end
        pad_in = 4'b1010;
        for (int k = 1; k <= 6; k++) begin
            step();
            expect_v("db_multi", 2'd1, (k >= 6) ? 32'hA : 32'h1);
        end

        // PWM / blink / invert / direct on independent channels
        bus.gpio_dir_i = 32'h0000_0F00;
        bus.gpio_out_i = 32'h0000_0F00;
        mode = 8'b00_01_10_11;
        for (int d = 0; d < 3; d++) begin
            duty = duties[d];
            for (int c = 0; c < 256; c++) begin
                step();
                expect_pad_model("pwm_blink");
                if (d == 2 && c == 127) bus.gpio_out_i[10:9] = 2'b00;
            end
        end
        bus.gpio_out_i = 32'h0000_0F00;

        // Lock loss and re-lock
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_v("drop_soc", 2'd0, (k >= 3) ? 32'd0 : 32'd1);
        end
        step();
        expect_v("drop_pad", 2'd2, 32'd0);
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_v("relock_soc", 2'd0, (k >= 10) ? 32'd1 : 32'd0);
        end
        repeat (20) begin
            step();
            expect_pad_model("relock_pad");
        end
        expect_v("pre_rst_gpio", 2'd1, 32'hA);

        // Asynchronous reset mid-operation: outputs clear before the next edge
        step();
        rst_n = 1'b0;
        expect_v("arst_soc", 2'd0, 32'd0);
        expect_v("arst_gpio", 2'd1, 32'd0);
        expect_v("arst_pad", 2'd2, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        expect_v("post_soc", 2'd0, 32'd0);
        expect_v("post_gpio", 2'd1, 32'd0);
        repeat (2) step();

        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
